// File: rtl/dac_calib_pkg.sv
// Shared calibration constants and the saturating clamp. The DAC and ADC calibration stages
// both use this package.
package dac_calib_pkg;

  localparam int unsigned GAIN_FRAC_BITS = 15;
  localparam logic [15:0] GAIN_UNITY     = 16'h8000;

  typedef struct packed {
    logic               sat;
    logic signed [31:0] value;
  } clamp_t;

  // Clamp a signed value to the two's-complement range of `width` bits and flag the clamp.
  function automatic clamp_t sat_clamp(input logic signed [31:0] val, input int unsigned width);
    clamp_t             r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (val > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (val < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end else begin
      r.sat   = 1'b0;
      r.value = val;
    end
    return r;
  endfunction

endpackage

// File: rtl/calib_mac_sat.sv
// Two-stage gain/offset datapath: registered Q1.15 multiply, then offset add, clamp and output
// register. All state advances only when en is high.
module calib_mac_sat
  import dac_calib_pkg::*;
#(
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic [15:0]          gain,
  input  logic [15:0]          offset,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 sat_event
);

  localparam int unsigned PW = DATA_BITS + 17;
  localparam int unsigned GW = DATA_BITS + 2;
  localparam int unsigned SW = DATA_BITS + 3;

  logic signed [PW-1:0] prod;
  logic signed [GW-1:0] scaled_q;
  logic                 s2_valid_q;
  logic signed [SW-1:0] sum;
  clamp_t               clamp_res;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign prod = $signed({{17{in_data[DATA_BITS-1]}}, in_data}) *
                $signed({{(DATA_BITS + 1){1'b0}}, gain});

  assign sum       = {scaled_q[GW-1], scaled_q} + {{(SW - 16){offset[15]}}, offset};
  assign clamp_res = sat_clamp(32'(sum), DATA_BITS);
  assign sat_event = en && s2_valid_q && clamp_res.sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      scaled_q   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else if (en) begin
      s2_valid_q <= in_valid;
      scaled_q   <= GW'(prod >>> GAIN_FRAC_BITS);
      out_valid  <= s2_valid_q;
      out_data   <= DATA_BITS'(clamp_res.value);
    end
  end

endmodule

// File: rtl/dac_calib.sv
// DAC-side calibration: gain then offset on the generator stream, with a global-stall AXI-S
// pipeline and a sticky saturation counter.
module dac_calib
  import dac_calib_pkg::*;
#(
  parameter int unsigned AXIS_DATA_BITS = 16,
  parameter int unsigned SAT_CNT_BITS   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXIS_DATA_BITS-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [AXIS_DATA_BITS-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [15:0]               cfg_calib_gain,
  input  logic [15:0]               cfg_calib_offset,
  input  logic                      sat_clr,
  output logic [SAT_CNT_BITS-1:0]   sat_cnt,
  output logic                      sat_flag
);

  logic                      adv;
  logic                      s1_valid_q;
  logic [AXIS_DATA_BITS-1:0] s1_data_q;
  logic [15:0]               gain_q;
  logic [15:0]               offset_q;
  logic                      sat_event;

  // No skid buffer: ready is combinational from downstream ready.
  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv;

  // Config is sampled every cycle, independent of stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      gain_q   <= '0;
      offset_q <= '0;
    end else begin
      gain_q   <= cfg_calib_gain;
      offset_q <= cfg_calib_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= s_axis_tvalid;
      s1_data_q  <= s_axis_tdata;
    end
  end

  calib_mac_sat #(
    .DATA_BITS(AXIS_DATA_BITS)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (adv),
    .in_valid (s1_valid_q),
    .in_data  (s1_data_q),
    .gain     (gain_q),
    .offset   (offset_q),
    .out_valid(m_axis_tvalid),
    .out_data (m_axis_tdata),
    .sat_event(sat_event)
  );

  // Clear wins over a same-cycle event.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (sat_event) begin
      sat_flag <= 1'b1;
      if (sat_cnt != '1) begin
        sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_calib.sv
// Directed bench for dac_calib: vector table for arithmetic, hand sequences for stall,
// saturation counting and reset.
module tb_dac_calib;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] cfg_calib_gain;
  logic [15:0] cfg_calib_offset;
  logic        sat_clr;
  logic [15:0] sat_cnt;
  logic        sat_flag;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;
  logic exp_flag = 1'b0;

  typedef struct {
    logic [15:0] gain;
    logic [15:0] offset;
    logic [15:0] din;
    logic [15:0] dout;
    logic        sat;
  } vec_t;

  vec_t vecs[12];

  dac_calib #(
    .AXIS_DATA_BITS(16),
    .SAT_CNT_BITS  (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tready   (m_axis_tready),
    .cfg_calib_gain  (cfg_calib_gain),
    .cfg_calib_offset(cfg_calib_offset),
    .sat_clr         (sat_clr),
    .sat_cnt         (sat_cnt),
    .sat_flag        (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_pulse();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    exp_cnt  = 0;
    exp_flag = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    cfg_calib_gain   = v.gain;
    cfg_calib_offset = v.offset;
    m_axis_tready    = 1'b1;
    tick();
    tick();
    s_axis_tdata  = v.din;
    s_axis_tvalid = 1'b1;
    check({tag, "_in_ready"}, 32'(s_axis_tready), 32'd1);
    tick();
    s_axis_tvalid = 1'b0;
    n = 1;
    while (!m_axis_tvalid && n < 8) begin
      tick();
      n++;
    end
    if (v.sat) begin
      exp_cnt++;
      exp_flag = 1'b1;
    end
    check({tag, "_latency"}, 32'(n), 32'd3);
    check({tag, "_dout"}, 32'(m_axis_tdata), 32'(v.dout));
    check({tag, "_sat_cnt"}, 32'(sat_cnt), 32'(exp_cnt));
    check({tag, "_sat_flag"}, 32'(sat_flag), 32'(exp_flag));
    tick();
  endtask

  initial begin
    int   next_in;
    int   exp_out;
    int   cyc;
    int   seen;
    logic stalled;
    logic [15:0] held;
    vec_t v;

    vecs[0]  = '{16'h8000, 16'h0000, 16'h1234, 16'h1234, 1'b0};
    vecs[1]  = '{16'h4000, 16'hFF9C, 16'h03E8, 16'h0190, 1'b0};  // 1000*0.5-100 = 400
    vecs[2]  = '{16'h4000, 16'hFF9C, 16'hFFFD, 16'hFF9A, 1'b0};  // floor(-1.5)-100 = -102
    vecs[3]  = '{16'hFFFF, 16'h0000, 16'h7000, 16'h7FFF, 1'b1};
    vecs[4]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 1'b1};
    vecs[5]  = '{16'h8000, 16'h0064, 16'h7FF0, 16'h7FFF, 1'b1};
    vecs[6]  = '{16'h0000, 16'h0005, 16'hFB2E, 16'h0005, 1'b0};
    vecs[7]  = '{16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0};
    vecs[8]  = '{16'h8000, 16'h8000, 16'hFFFF, 16'h8000, 1'b1};
    vecs[9]  = '{16'h6000, 16'h0000, 16'hFF9B, 16'hFFB4, 1'b0};  // floor(-75.75) = -76
    vecs[10] = '{16'hC000, 16'h0000, 16'h4E20, 16'h7530, 1'b0};
    vecs[11] = '{16'hC000, 16'h0000, 16'h55F0, 16'h7FFF, 1'b1};

    rst              = 1'b1;
    s_axis_tdata     = '0;
    s_axis_tvalid    = 1'b0;
    m_axis_tready    = 1'b1;
    cfg_calib_gain   = 16'h8000;
    cfg_calib_offset = '0;
    sat_clr          = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Ten saturating samples back to back, then clear.
    cfg_calib_gain   = 16'hFFFF;
    cfg_calib_offset = 16'h0000;
    clr_pulse();
    tick();
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      s_axis_tvalid = (i < 10);
      s_axis_tdata  = 16'h7000;
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tdata == 16'h7FFF) seen++;
      tick();
    end
    s_axis_tvalid = 1'b0;
    check("satstream_outputs", 32'(seen), 32'd10);
    check("satstream_cnt", 32'(sat_cnt), 32'd10);
    check("satstream_flag", 32'(sat_flag), 32'd1);
    clr_pulse();
    check("satclr_cnt", 32'(sat_cnt), 32'd0);
    check("satclr_flag", 32'(sat_flag), 32'd0);

    // Clear coincident with a negative-saturation event.
    cfg_calib_gain   = 16'h8000;
    cfg_calib_offset = 16'hFFFF;
    tick();
    tick();
    s_axis_tdata  = 16'h8000;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("clrhit_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("clrhit_dout", 32'(m_axis_tdata), 32'h8000);
    check("clrhit_cnt", 32'(sat_cnt), 32'd0);
    check("clrhit_flag", 32'(sat_flag), 32'd0);
    tick();
    exp_cnt  = 0;
    exp_flag = 1'b0;
    v = '{16'h8000, 16'hFFFF, 16'h8000, 16'h8000, 1'b1};
    run_vec(v, "negsat");

    // Ramp 0..31 with downstream stalled for 5 cycles mid-stream.
    cfg_calib_gain   = 16'h8000;
    cfg_calib_offset = 16'h0000;
    tick();
    tick();
    next_in = 0;
    exp_out = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (exp_out < 32 && cyc < 200) begin
      m_axis_tready = !(cyc >= 12 && cyc < 17);
      s_axis_tvalid = (next_in < 32);
      s_axis_tdata  = 16'(next_in);
      @(negedge clk);
      if (!m_axis_tready && m_axis_tvalid) begin
        check($sformatf("bp_in_ready_c%0d", cyc), 32'(s_axis_tready), 32'd0);
        if (stalled) check($sformatf("bp_hold_c%0d", cyc), 32'(m_axis_tdata), 32'(held));
        held    = m_axis_tdata;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check($sformatf("bp_out%0d", exp_out), 32'(m_axis_tdata), 32'(exp_out));
        exp_out++;
      end
      if (s_axis_tvalid && s_axis_tready) next_in++;
      tick();
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    check("bp_total", 32'(exp_out), 32'd32);
    tick();
    tick();
    tick();

    // Reset with three samples in flight.
    cfg_calib_gain   = 16'hFFFF;
    cfg_calib_offset = 16'h0000;
    clr_pulse();
    tick();
    s_axis_tdata  = 16'h7000;
    s_axis_tvalid = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("pre_rst_cnt", 32'(sat_cnt), 32'd1);
    rst          = 1'b1;
    s_axis_tdata = 16'h1111;
    check("in_rst_tready", 32'(s_axis_tready), 32'd1);
    tick();
    rst           = 1'b0;
    s_axis_tvalid = 1'b0;
    check("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("post_rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("post_rst_cnt", 32'(sat_cnt), 32'd0);
    check("post_rst_flag", 32'(sat_flag), 32'd0);
    check("post_rst_tready", 32'(s_axis_tready), 32'd1);
    exp_cnt  = 0;
    exp_flag = 1'b0;
    seen     = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_axis_tvalid) seen++;
      tick();
    end
    check("rst_flush", 32'(seen), 32'd0);
    v = '{16'h8000, 16'h0000, 16'h0555, 16'h0555, 1'b0};
    run_vec(v, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
